// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified instruction/data memory arbiter.
package mem_arbiter_pkg;

   localparam logic [1:0] MEM_NOP   = 2'd0;
   localparam logic [1:0] MEM_READ  = 2'd1;
   localparam logic [1:0] MEM_WRITE = 2'd2;

   localparam int unsigned RUN_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   // Only READ and WRITE count as a data request; 2'b11 behaves as NOP.
   function automatic logic is_data_req(input logic [1:0] action);
      return (action == MEM_READ) || (action == MEM_WRITE);
   endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Grant selection between fetch and data, with a bounded data-run counter
// that keeps a pending fetch from being starved.
module mem_arb_prio
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned MAX_DATA_RUN = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic idle,
   input  logic f_req,
   input  logic d_req,
   output logic grant_fetch_c,
   output logic grant_data_c
);

   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);

   logic [RUN_W-1:0] run_cnt;
   logic             run_full;

   assign run_full = (run_cnt == RUN_MAX);

   // Data has priority unless it has used up its run while fetch waited.
   always_comb begin
      grant_fetch_c = 1'b0;
      grant_data_c  = 1'b0;
      if (idle) begin
         if (f_req && d_req) begin
            grant_fetch_c = run_full;
            grant_data_c  = !run_full;
         end else begin
            grant_fetch_c = f_req;
            grant_data_c  = d_req;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_cnt <= '0;
      end else if (idle) begin
         if (grant_fetch_c || !f_req) begin
            run_cnt <= '0;
         end else if (grant_data_c && !run_full) begin
            run_cnt <= run_cnt + RUN_W'(1);
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch
// (16-bit halfwords) and load/store (32-bit words); one access per 3 cycles.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned AW           = 32,
   parameter int unsigned MAW          = AW - 2,
   parameter int unsigned MAX_DATA_RUN = 4
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_f_req,
   input  logic [AW-1:0]  i_f_addr,
   output logic           o_f_ack,
   output logic [15:0]    o_f_data,
   input  logic [1:0]     i_d_action,
   input  logic [AW-1:0]  i_d_addr,
   input  logic [31:0]    i_d_wdata,
   output logic           o_d_ack,
   output logic [31:0]    o_d_rdata,
   output logic           o_mem_en,
   output logic           o_mem_we,
   output logic [MAW-1:0] o_mem_addr,
   output logic [31:0]    o_mem_wdata,
   input  logic [31:0]    i_mem_rdata,
   output logic           o_busy
);

   state_t         state;
   logic           win_fetch;
   logic           win_write;
   logic           half_sel;
   logic           d_req;
   logic           grant_fetch;
   logic           grant_data;
   logic [AW-1:0]  sel_addr;
   logic           unused_addr_bit;

   assign d_req           = is_data_req(i_d_action);
   assign sel_addr        = grant_fetch ? i_f_addr : i_d_addr;
   assign unused_addr_bit = sel_addr[0];

   mem_arb_prio #(
      .MAX_DATA_RUN (MAX_DATA_RUN)
   ) u_prio (
      .clk           (i_clk),
      .rst_n         (i_rst),
      .idle          (state == ST_IDLE),
      .f_req         (i_f_req),
      .d_req         (d_req),
      .grant_fetch_c (grant_fetch),
      .grant_data_c  (grant_data)
   );

   // IDLE latches the winner and presents it to the RAM on entry to ISSUE;
   // the RAM's read data is captured at the end of RESP with the ack.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state       <= ST_IDLE;
         win_fetch   <= 1'b0;
         win_write   <= 1'b0;
         half_sel    <= 1'b0;
         o_f_ack     <= 1'b0;
         o_f_data    <= '0;
         o_d_ack     <= 1'b0;
         o_d_rdata   <= '0;
         o_mem_en    <= 1'b0;
         o_mem_we    <= 1'b0;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
         o_busy      <= 1'b0;
      end else begin
         o_f_ack <= 1'b0;
         o_d_ack <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (grant_fetch || grant_data) begin
                  win_fetch   <= grant_fetch;
                  win_write   <= grant_data && (i_d_action == MEM_WRITE);
                  half_sel    <= sel_addr[1];
                  o_mem_en    <= 1'b1;
                  o_mem_we    <= grant_data && (i_d_action == MEM_WRITE);
                  o_mem_addr  <= MAW'(sel_addr[AW-1:2]);
                  o_mem_wdata <= i_d_wdata;
                  o_busy      <= 1'b1;
                  state       <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               o_mem_en <= 1'b0;
               o_mem_we <= 1'b0;
               state    <= ST_RESP;
            end
            ST_RESP: begin
               o_busy <= 1'b0;
               state  <= ST_IDLE;
               if (win_fetch) begin
                  o_f_ack  <= 1'b1;
                  o_f_data <= half_sel ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
               end else begin
                  o_d_ack <= 1'b1;
                  if (!win_write) begin
                     o_d_rdata <= i_mem_rdata;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small synchronous RAM model.
module tb_mem_arbiter;

   localparam int unsigned AW  = 32;
   localparam int unsigned MAW = 30;

   logic           i_clk = 1'b0;
   logic           i_rst = 1'b0;
   logic           i_f_req = 1'b0;
   logic [AW-1:0]  i_f_addr = '0;
   logic           o_f_ack;
   logic [15:0]    o_f_data;
   logic [1:0]     i_d_action = 2'd0;
   logic [AW-1:0]  i_d_addr = '0;
   logic [31:0]    i_d_wdata = '0;
   logic           o_d_ack;
   logic [31:0]    o_d_rdata;
   logic           o_mem_en;
   logic           o_mem_we;
   logic [MAW-1:0] o_mem_addr;
   logic [31:0]    o_mem_wdata;
   logic [31:0]    i_mem_rdata = '0;
   logic           o_busy;

   logic [31:0] ram [0:63];
   int n_checks = 0;
   int n_pass   = 0;

   mem_arbiter #(.AW(AW), .MAW(MAW), .MAX_DATA_RUN(4)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_f_req     (i_f_req),
      .i_f_addr    (i_f_addr),
      .o_f_ack     (o_f_ack),
      .o_f_data    (o_f_data),
      .i_d_action  (i_d_action),
      .i_d_addr    (i_d_addr),
      .i_d_wdata   (i_d_wdata),
      .o_d_ack     (o_d_ack),
      .o_d_rdata   (o_d_rdata),
      .o_mem_en    (o_mem_en),
      .o_mem_we    (o_mem_we),
      .o_mem_addr  (o_mem_addr),
      .o_mem_wdata (o_mem_wdata),
      .i_mem_rdata (i_mem_rdata),
      .o_busy      (o_busy)
   );

   always #5 i_clk = ~i_clk;

   // Single-port RAM: read data appears the cycle after the enable.
   always @(posedge i_clk) begin
      if (o_mem_en) begin
         if (o_mem_we) ram[o_mem_addr[5:0]] <= o_mem_wdata;
         else          i_mem_rdata <= ram[o_mem_addr[5:0]];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_fetch(input logic [31:0] addr, input logic [15:0] exp, input string tag);
      int n = 0;
      i_f_req  = 1'b1;
      i_f_addr = addr;
      do begin
         tick();
         n++;
      end while (!o_f_ack && n < 10);
      check({tag, "_lat"}, 32'(n), 32'd3);
      check({tag, "_data"}, 32'(o_f_data), 32'(exp));
      i_f_req = 1'b0;
   endtask

   task automatic do_data(input logic [1:0] act, input logic [31:0] addr,
                          input logic [31:0] wd, input string tag);
      int n = 0;
      i_d_action = act;
      i_d_addr   = addr;
      i_d_wdata  = wd;
      do begin
         tick();
         n++;
      end while (!o_d_ack && n < 10);
      check({tag, "_lat"}, 32'(n), 32'd3);
      i_d_action = 2'd0;
   endtask

   initial begin
      logic [9:0] exp_order;
      logic       any_activity;
      int         f_seen;
      int         n;

      for (int i = 0; i < 64; i++) ram[i] = '0;
      ram[1] = 32'hBEEF_1234;

      tick();
      tick();
      check("rst_outputs", {o_f_ack, o_d_ack, o_mem_en, o_mem_we, o_busy}, '0);
      check("rst_data", {o_f_data, o_d_rdata[15:0]} | 32'(o_mem_addr) | o_mem_wdata, '0);
      i_rst = 1'b1;
      tick();

      // Fetch only: upper and lower halfword of word 1
      do_fetch(32'h6, 16'hBEEF, "fetch_hi");
      tick();
      check("f_ack_pulse", 32'(o_f_ack), 32'd0);
      do_fetch(32'h4, 16'h1234, "fetch_lo");
      tick();

      // Data write to word 4, inspecting the RAM strobes cycle by cycle
      i_d_action = 2'd2;
      i_d_addr   = 32'h10;
      i_d_wdata  = 32'hA5A5_0001;
      tick();
      check("wr_issue", {o_mem_en, o_mem_we, o_busy}, 32'b111);
      check("wr_addr", 32'(o_mem_addr), 32'd4);
      check("wr_wdata", o_mem_wdata, 32'hA5A5_0001);
      tick();
      check("wr_resp", {o_mem_en, o_d_ack, o_busy}, 32'b001);
      tick();
      check("wr_ack", {o_d_ack, o_busy}, 32'b10);
      check("wr_rdata_kept", o_d_rdata, 32'h0);
      i_d_action = 2'd0;
      check("wr_ram", ram[4], 32'hA5A5_0001);
      tick();
      check("d_ack_pulse", 32'(o_d_ack), 32'd0);

      do_data(2'd1, 32'h13, 32'h0, "rd_13");
      check("rd_data", o_d_rdata, 32'hA5A5_0001);
      tick();

      // Undefined action 2'b11 must be ignored
      i_d_action   = 2'd3;
      any_activity = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         any_activity |= o_mem_en | o_busy | o_d_ack | o_f_ack;
      end
      check("nop3_idle", 32'(any_activity), 32'd0);
      i_d_action = 2'd0;
      tick();

      // Continuous fetch + data: four data grants then one fetch
      exp_order = 10'b10000_10000;  // bit i = 1 means grant i is a fetch
      i_f_req    = 1'b1;
      i_f_addr   = 32'h4;
      i_d_action = 2'd1;
      i_d_addr   = 32'h10;
      for (int g = 0; g < 10; g++) begin
         n = 0;
         do begin
            tick();
            n++;
         end while (!o_f_ack && !o_d_ack && n < 10);
         check($sformatf("grant%0d_fetch", g), 32'(o_f_ack), 32'(exp_order[g]));
         check($sformatf("grant%0d_lat", g), 32'(n), 32'd3);
      end
      i_f_req    = 1'b0;
      i_d_action = 2'd0;
      tick();
      tick();

      // Fetch dropped in its ack cycle while a data request waits
      i_f_req  = 1'b1;
      i_f_addr = 32'h4;
      tick();
      i_d_action = 2'd1;
      i_d_addr   = 32'h10;
      tick();
      tick();
      check("drop_f_ack", {16'(o_f_ack), o_f_data}, {16'd1, 16'h1234});
      i_f_req = 1'b0;
      f_seen  = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         f_seen += int'(o_f_ack);
      end
      check("drop_d_ack", 32'(o_d_ack), 32'd1);
      check("drop_no_f", 32'(f_seen), 32'd0);
      i_d_action = 2'd0;
      tick();

      // Reset asserted while a read is in ISSUE
      i_d_action = 2'd1;
      i_d_addr   = 32'h4;
      tick();
      check("rst_issue_en", 32'(o_mem_en), 32'd1);
      #1 i_rst = 1'b0;
      #1;
      check("rst_async_ctl", {o_f_ack, o_d_ack, o_mem_en, o_mem_we, o_busy}, '0);
      check("rst_async_rdata", o_d_rdata, '0);
      check("rst_async_misc", 32'(o_f_data) | 32'(o_mem_addr) | o_mem_wdata, '0);
      i_d_action = 2'd0;
      i_f_req    = 1'b1;
      i_f_addr   = 32'h6;
      tick();
      check("rst_hold_ack", {o_f_ack, o_d_ack, o_busy}, '0);
      i_rst = 1'b1;
      do_fetch(32'h6, 16'hBEEF, "post_rst");
      check("post_rst_no_d", 32'(o_d_ack), 32'd0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
